// File: rtl/bus_ctrl.sv
// bus_ctrl: serves the core's single memory port from an external synchronous RAM or a small IO block.
// Optional feature macro: BUS_CYCLE_COUNTER_EN builds the 32-bit cycle counter readable at 0x8004.
module bus_ctrl #(
  parameter int RAM_AW = 13,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [15:0]       addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [GPIO_W-1:0] gpio
);

  localparam logic [13:0] GPIO_WA = 14'h2000;
  localparam logic [13:0] CNT_WA  = 14'h2001;
  localparam logic [13:0] STAT_WA = 14'h2002;

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} state_e;

  state_e            state_q, state_d;
  logic [13:0]       rdWa_q, rdWa_d;
  logic [31:0]       rdData_q, rdData_d;
  logic              rdValid_q, rdValid_d;
  logic [RAM_AW-1:0] ramAddr_q, ramAddr_d;
  logic              ramWe_q, ramWe_d;
  logic [31:0]       ramWdata_q, ramWdata_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              err_q, err_d;

  logic [13:0] reqWa;
  logic        busy, reqRam, reqX0;
  logic        rdAccept, ramWr, ioWr, errSet, errClr;
  logic [31:0] cycleCnt, ioRdata, rdMux;
  logic [1:0]  unusedAddrLsb;

  assign unusedAddrLsb = addr[1:0];

  assign reqWa  = addr[15:2];
  assign reqRam = ~addr[15];
  assign reqX0  = (reqWa == 14'd0);
  assign busy   = (state_q != IDLE);

  // A read is only taken from IDLE and never alongside a write; RAM writes
  // must not disturb the address a pending read has put on the RAM.
  assign rdAccept = rd_en & ~wr_en & ~busy;
  assign ramWr    = wr_en & reqRam & ~reqX0 & ~busy;
  assign ioWr     = wr_en & ~reqRam;
  assign errSet   = (rd_en & wr_en & ~busy) | (busy & rd_en) | (busy & wr_en & reqRam);
  assign errClr   = ioWr & (reqWa == STAT_WA) & wr_data[0];

`ifdef BUS_CYCLE_COUNTER_EN
  logic [31:0] cycleCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_q + 32'd1;
    end
  end

  assign cycleCnt = cycleCnt_q;
`else
  assign cycleCnt = '0;
`endif

  always_comb begin
    ioRdata = '0;
    case (rdWa_q)
      GPIO_WA: ioRdata = 32'(gpio_q);
      CNT_WA:  ioRdata = cycleCnt;
      STAT_WA: ioRdata = {31'd0, err_q};
      default: ioRdata = '0;
    endcase
    if (rdWa_q[13]) begin
      rdMux = ioRdata;
    end else if (rdWa_q == 14'd0) begin
      rdMux = '0;
    end else begin
      rdMux = ram_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    rdWa_d     = rdWa_q;
    rdData_d   = rdData_q;
    rdValid_d  = 1'b0;
    ramAddr_d  = ramAddr_q;
    ramWe_d    = ramWr;
    ramWdata_d = ramWdata_q;
    gpio_d     = gpio_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (rdAccept) begin
          rdWa_d  = reqWa;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rdData_d  = rdMux;
        rdValid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rdAccept || ramWr) begin
      ramAddr_d = addr[RAM_AW+1:2];
    end
    if (ramWr) begin
      ramWdata_d = wr_data;
    end
    if (ioWr && (reqWa == GPIO_WA)) begin
      gpio_d = wr_data[GPIO_W-1:0];
    end

    // A new error in the same cycle as a clearing write stays visible.
    if (errSet) begin
      err_d = 1'b1;
    end else if (errClr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdWa_q     <= '0;
      rdData_q   <= '0;
      rdValid_q  <= 1'b0;
      ramAddr_q  <= '0;
      ramWe_q    <= 1'b0;
      ramWdata_q <= '0;
      gpio_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdWa_q     <= rdWa_d;
      rdData_q   <= rdData_d;
      rdValid_q  <= rdValid_d;
      ramAddr_q  <= ramAddr_d;
      ramWe_q    <= ramWe_d;
      ramWdata_q <= ramWdata_d;
      gpio_q     <= gpio_d;
      err_q      <= err_d;
    end
  end

  assign rd_data   = rdData_q;
  assign rd_valid  = rdValid_q;
  assign ram_addr  = ramAddr_q;
  assign ram_we    = ramWe_q;
  assign ram_wdata = ramWdata_q;
  assign gpio      = gpio_q;

endmodule
